// File: rtl/pattern_playback.sv
// Multi-channel pattern generator: bytes are loaded into per-channel bit buffers,
// then all channels shift out MSB-first in lockstep at a prescaled tick rate.
module pattern_playback #(
    parameter int unsigned NUM_CHANNELS = 7,
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned SAMPLES      = 10,
    parameter int unsigned DIV_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [NUM_BITS-1:0]     wr_data,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [DIV_WIDTH-1:0]    div,
    output logic [NUM_CHANNELS-1:0] ch_out,
    output logic                    busy,
    output logic                    done,
    output logic                    load_full
);

    localparam int unsigned BUFFER_SIZE = NUM_BITS * SAMPLES;
    localparam int unsigned TOTAL_BYTES = NUM_CHANNELS * SAMPLES;
    localparam int unsigned BP_W = $clog2(BUFFER_SIZE);
    localparam int unsigned WP_W = $clog2(TOTAL_BYTES + 1);
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [BP_W-1:0] LAST_BIT  = BP_W'(BUFFER_SIZE - 1);
    localparam logic [BP_W-1:0] LAST_BYTE = BP_W'(NUM_BITS - 1);
    localparam logic [BP_W-1:0] BYTE_STEP = BP_W'(NUM_BITS);
    localparam logic [WP_W-1:0] WR_LIMIT  = WP_W'(TOTAL_BYTES);

    typedef enum logic [0:0] {
        IDLE,
        PLAY
    } state_e;

    state_e                  state_q, state_d;
    logic [BUFFER_SIZE-1:0]  mem_q [NUM_CHANNELS];
    logic [BUFFER_SIZE-1:0]  mem_d [NUM_CHANNELS];
    logic [WP_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CH_W-1:0]         wr_ch_q, wr_ch_d;
    logic [BP_W-1:0]         wr_base_q, wr_base_d;
    logic [BP_W-1:0]         bit_ptr_q, bit_ptr_d;
    logic [DIV_WIDTH-1:0]    pre_q, pre_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d;
    logic                    load_full_q, load_full_d;
    logic [NUM_CHANNELS-1:0] ch_out_q, ch_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    finish;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_ch_q     <= '0;
            wr_base_q   <= LAST_BIT;
            bit_ptr_q   <= LAST_BIT;
            pre_q       <= '0;
            div_q       <= '0;
            load_full_q <= 1'b0;
            ch_out_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_ch_q     <= wr_ch_d;
            wr_base_q   <= wr_base_d;
            bit_ptr_q   <= bit_ptr_d;
            pre_q       <= pre_d;
            div_q       <= div_d;
            load_full_q <= load_full_d;
            ch_out_q    <= ch_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_ch_d     = wr_ch_q;
        wr_base_d   = wr_base_q;
        bit_ptr_d   = bit_ptr_q;
        pre_d       = pre_q;
        div_d       = div_q;
        load_full_d = load_full_q;
        finish      = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            mem_d[i] = mem_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PLAY;
                    div_d       = div;
                    bit_ptr_d   = LAST_BIT;
                    pre_d       = '0;
                    wr_ptr_d    = '0;
                    wr_ch_d     = '0;
                    wr_base_d   = LAST_BIT;
                    load_full_d = 1'b0;
                end else if (wr_en && (wr_ptr_q < WR_LIMIT)) begin
                    // Channel/byte position tracked incrementally instead of wr_ptr/SAMPLES
                    mem_d[wr_ch_q][wr_base_q -: NUM_BITS] = wr_data;
                    wr_ptr_d = wr_ptr_q + WP_W'(1);
                    if (wr_base_q == LAST_BYTE) begin
                        wr_base_d = LAST_BIT;
                        wr_ch_d   = wr_ch_q + CH_W'(1);
                    end else begin
                        wr_base_d = wr_base_q - BYTE_STEP;
                    end
                    load_full_d = (wr_ptr_d == WR_LIMIT);
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pre_q == div_q) begin
                    pre_d = '0;
                    if (bit_ptr_q == '0) begin
                        if (loop_en) begin
                            bit_ptr_d = LAST_BIT;
                        end else begin
                            state_d = IDLE;
                            finish  = 1'b1;
                        end
                    end else begin
                        bit_ptr_d = bit_ptr_q - BP_W'(1);
                    end
                end else begin
                    pre_d = pre_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs follow the bit selected for the coming cycle
    always_comb begin
        ch_out_d = '0;
        busy_d   = (state_d == PLAY);
        done_d   = finish;
        if (state_d == PLAY) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                ch_out_d[i] = mem_q[i][bit_ptr_d];
            end
        end
    end

    assign ch_out    = ch_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign load_full = load_full_q;

endmodule

// File: tb/tb_pattern_playback.sv
// Scoreboard bench for pattern_playback: a bench-side buffer model predicts every
// output cycle of a playback, and each test compares the DUT against it.
module tb_pattern_playback;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] div = '0;
    logic [6:0] ch_out;
    logic       busy;
    logic       done;
    logic       load_full;

    int errors = 0;
    int checks = 0;

    logic [79:0] mbuf [7];
    int          mptr = 0;
    logic [8:0]  sb [$];

    pattern_playback #(
        .NUM_CHANNELS(7),
        .NUM_BITS(8),
        .SAMPLES(10),
        .DIV_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .div(div),
        .ch_out(ch_out),
        .busy(busy),
        .done(done),
        .load_full(load_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 7; c++) mbuf[c] = '0;
        mptr = 0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        int c;
        int j;
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
        if (mptr < 70) begin
            c = mptr / 10;
            j = mptr % 10;
            for (int k = 0; k < 8; k++) mbuf[c][72 - 8*j + k] = b[k];
            mptr++;
        end
    endtask

    function automatic logic [6:0] model_col(input int idx);
        logic [6:0] r;
        for (int c = 0; c < 7; c++) r[c] = mbuf[c][idx];
        return r;
    endfunction

    // Expected {ch_out, busy, done} for cycles T+1..T+n after a start at T
    task automatic sb_push_play(input int d, input bit lp, input int n);
        int hold;
        int idx;
        hold = d + 1;
        for (int k = 1; k <= n; k++) begin
            if (!lp && k > 80 * hold) begin
                sb.push_back({7'b0, 1'b0, (k == 80 * hold + 1)});
            end else begin
                idx = 79 - (((k - 1) / hold) % 80);
                sb.push_back({model_col(idx), 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({ch_out, busy, done, load_full} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got ch=%b busy=%b done=%b full=%b, expected all 0",
                     ch_out, busy, done, load_full);
        end
        reset = 1'b0;
        model_clear();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        checks++;
        if ({ch_out, busy, done, load_full} !== 10'b0) begin
            errors++;
            $display("FAIL stop_in_idle: got ch=%b busy=%b done=%b full=%b, expected all 0",
                     ch_out, busy, done, load_full);
        end
    endtask

    task automatic test_alternating();
        logic [8:0] e;
        for (int i = 0; i < 70; i++) begin
            wr_byte(8'hA5);
            if (i == 68 || i == 69) begin
                checks++;
                if (load_full !== (i == 69)) begin
                    errors++;
                    $display("FAIL alt_load_full after write %0d: got %b, expected %b",
                             i + 1, load_full, (i == 69));
                end
            end
        end
        start = 1'b1; div = 8'd0; loop_en = 1'b0;
        mptr = 0;
        sb_push_play(0, 1'b0, 83);
        for (int k = 1; k <= 83; k++) begin
            step();
            start = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({ch_out, busy, done} !== e) begin
                errors++;
                $display("FAIL alt_play T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                         k, ch_out, busy, done, e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_div();
        logic [8:0] e;
        wr_byte(8'h80);
        for (int i = 1; i < 10; i++) wr_byte(8'h00);
        for (int i = 10; i < 70; i++) wr_byte(8'hFF);
        start = 1'b1; div = 8'd3; loop_en = 1'b0;
        mptr = 0;
        sb_push_play(3, 1'b0, 322);
        for (int k = 1; k <= 322; k++) begin
            step();
            start = 1'b0;
            div = 8'd0;
            e = sb.pop_front();
            checks++;
            if ({ch_out, busy, done} !== e) begin
                errors++;
                $display("FAIL div3_play T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                         k, ch_out, busy, done, e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_loop_stop();
        logic [8:0] e;
        wr_byte(8'h80);
        for (int i = 1; i < 9; i++) wr_byte(8'h00);
        wr_byte(8'h01);
        for (int i = 10; i < 70; i++) wr_byte(8'($urandom));
        start = 1'b1; div = 8'd0; loop_en = 1'b1;
        mptr = 0;
        sb_push_play(0, 1'b1, 100);
        sb.push_back(9'b0);
        sb.push_back(9'b0);
        for (int k = 1; k <= 102; k++) begin
            step();
            start = 1'b0;
            stop = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({ch_out, busy, done} !== e) begin
                errors++;
                $display("FAIL loop_play T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                         k, ch_out, busy, done, e[8:2], e[1], e[0]);
            end
            if (k == 100) stop = 1'b1;
        end
        loop_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [8:0] e;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 75; i++) begin
            wr_byte(8'(i * 37 + 11));
            if (i == 68 || i == 69 || i == 74) begin
                checks++;
                if (load_full !== (i >= 69)) begin
                    errors++;
                    $display("FAIL ovf_load_full after write %0d: got %b, expected %b",
                             i + 1, load_full, (i >= 69));
                end
            end
        end
        start = 1'b1; wr_en = 1'b1; wr_data = 8'h3C; div = 8'd0;
        mptr = 0;
        sb_push_play(0, 1'b0, 82);
        for (int k = 1; k <= 82; k++) begin
            step();
            start = 1'b0;
            wr_en = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({ch_out, busy, done} !== e) begin
                errors++;
                $display("FAIL ovf_play T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                         k, ch_out, busy, done, e[8:2], e[1], e[0]);
            end
            if (k == 1) begin
                checks++;
                if (load_full !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full_cleared: got %b, expected 0", load_full);
                end
            end
        end
    endtask

    task automatic test_reset_midplay();
        logic [8:0] e;
        start = 1'b1; div = 8'd0;
        sb_push_play(0, 1'b0, 40);
        for (int k = 1; k <= 40; k++) begin
            step();
            start = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({ch_out, busy, done} !== e) begin
                errors++;
                $display("FAIL midrst_play T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                         k, ch_out, busy, done, e[8:2], e[1], e[0]);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        checks++;
        if ({ch_out, busy, done, load_full} !== 10'b0) begin
            errors++;
            $display("FAIL midrst_state: got ch=%b busy=%b done=%b full=%b, expected all 0",
                     ch_out, busy, done, load_full);
        end
        start = 1'b1;
        sb_push_play(0, 1'b0, 82);
        for (int k = 1; k <= 82; k++) begin
            step();
            start = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({ch_out, busy, done} !== e) begin
                errors++;
                $display("FAIL zero_play T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                         k, ch_out, busy, done, e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        for (int i = 0; i < 70; i++) begin
            wr_byte(8'($urandom));
            if (i == 68 || i == 69) begin
                checks++;
                if (load_full !== (i == 69)) begin
                    errors++;
                    $display("FAIL b2b_load_full after write %0d: got %b, expected %b",
                             i + 1, load_full, (i == 69));
                end
            end
        end
        for (int run = 0; run < 2; run++) begin
            start = 1'b1; div = 8'd1; loop_en = 1'b0;
            mptr = 0;
            sb_push_play(1, 1'b0, 161);
            for (int k = 1; k <= 161; k++) begin
                step();
                start = (k % 17 == 5) && (k < 150);
                wr_en = (k % 13 == 3) && (k < 150);
                wr_data = 8'($urandom);
                e = sb.pop_front();
                checks++;
                if ({ch_out, busy, done} !== e) begin
                    errors++;
                    $display("FAIL b2b_run%0d T+%0d: got ch=%b busy=%b done=%b, expected ch=%b busy=%b done=%b",
                             run, k, ch_out, busy, done, e[8:2], e[1], e[0]);
                end
            end
            start = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_alternating();
        test_div();
        test_loop_stop();
        test_overflow();
        test_reset_midplay();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
